// File: rtl/eth_bd_ram_ctrl.sv
// eth_bd_ram_ctrl: two-port round-robin initiator for a 256x32 byte-write descriptor SRAM with post-reset clear
// Ports: clk/rst (sync, active high); a_*/b_* request ports (valid/ready, we, be, addr, wdata)
// with registered read responses (rvalid pulse, rdata held); init_done; mem_* active-low macro pins
// (registered) plus mem_dout from the macro.
module eth_bd_ram_ctrl #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter logic [DW-1:0] INIT_VAL = '0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int NB = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [NB-1:0] a_be,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [NB-1:0] b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          init_done,
  output logic          mem_cen,
  output logic [NB-1:0] mem_wen,
  output logic          mem_oen,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_dout
);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_adr_q, clr_adr_d;
  logic          init_done_q, init_done_d;
  logic          prio_b_q, prio_b_d;
  logic          mem_cen_q, mem_cen_d, mem_oen_q, mem_oen_d;
  logic [NB-1:0] mem_wen_q, mem_wen_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [DW-1:0] mem_di_q, mem_di_d;
  logic [1:0]    tag_v_q, tag_v_d, tag_b_q, tag_b_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          grant_a, grant_b, acc, c_we;
  logic [NB-1:0] c_be;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;

  always_comb begin
    // prio_b_q set means B won nothing last time, so B wins the next contention
    grant_a = a_valid & (~b_valid | ~prio_b_q);
    grant_b = b_valid & ~grant_a;
    a_ready = init_done_q & grant_a;
    b_ready = init_done_q & grant_b;
    acc     = a_ready | b_ready;
    c_we    = b_ready ? b_we : a_we;
    c_be    = b_ready ? b_be : a_be;
    c_addr  = b_ready ? b_addr : a_addr;
    c_wdata = b_ready ? b_wdata : a_wdata;
    state_d     = state_q;
    clr_adr_d   = clr_adr_q;
    init_done_d = state_q == S_RUN;
    prio_b_d    = acc ? a_ready : prio_b_q;
    mem_cen_d   = 1'b1;
    mem_wen_d   = '1;
    mem_oen_d   = 1'b1;
    mem_adr_d   = mem_adr_q;
    mem_di_d    = mem_di_q;
    if (state_q == S_CLEAR) begin
      mem_cen_d = 1'b0;
      mem_wen_d = '0;
      mem_adr_d = clr_adr_q;
      mem_di_d  = INIT_VAL;
      clr_adr_d = clr_adr_q + 1'b1;
      state_d   = &clr_adr_q ? S_RUN : S_CLEAR;
    end else if (acc & (~c_we | (|c_be))) begin
      // a write with no byte enables is accepted but never reaches the macro
      mem_cen_d = 1'b0;
      mem_wen_d = c_we ? ~c_be : '1;
      mem_oen_d = c_we;
      mem_adr_d = c_addr;
      mem_di_d  = c_we ? c_wdata : mem_di_q;
    end
    // two-stage tag pipe: issue at E0, macro samples at E1, data captured at E2
    tag_v_d    = {tag_v_q[0], acc & ~c_we};
    tag_b_d    = {tag_b_q[0], b_ready};
    a_rvalid_d = tag_v_q[1] & ~tag_b_q[1];
    b_rvalid_d = tag_v_q[1] & tag_b_q[1];
    a_rdata_d  = a_rvalid_d ? mem_dout : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? mem_dout : b_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_adr_q   <= '0;
      init_done_q <= 1'b0;
      prio_b_q    <= 1'b0;
      mem_cen_q   <= 1'b1;
      mem_wen_q   <= '1;
      mem_oen_q   <= 1'b1;
      mem_adr_q   <= '0;
      mem_di_q    <= '0;
      tag_v_q     <= '0;
      tag_b_q     <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_adr_q   <= clr_adr_d;
      init_done_q <= init_done_d;
      prio_b_q    <= prio_b_d;
      mem_cen_q   <= mem_cen_d;
      mem_wen_q   <= mem_wen_d;
      mem_oen_q   <= mem_oen_d;
      mem_adr_q   <= mem_adr_d;
      mem_di_q    <= mem_di_d;
      tag_v_q     <= tag_v_d;
      tag_b_q     <= tag_b_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign init_done = init_done_q;
  assign mem_cen   = mem_cen_q;
  assign mem_wen   = mem_wen_q;
  assign mem_oen   = mem_oen_q;
  assign mem_adr   = mem_adr_q;
  assign mem_di    = mem_di_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_eth_bd_ram_ctrl.sv
// tb_eth_bd_ram_ctrl: randomized and directed self-checking bench for eth_bd_ram_ctrl
module tb_eth_bd_ram_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_we, a_rvalid;
  logic [3:0]  a_be;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_we, b_rvalid;
  logic [3:0]  b_be;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        init_done, mem_cen, mem_oen;
  logic [3:0]  mem_wen;
  logic [7:0]  mem_adr;
  logic [31:0] mem_di, mem_dout;

  eth_bd_ram_ctrl dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
    .mem_adr(mem_adr), .mem_di(mem_di), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // SRAM macro: byte writes and one-cycle synchronous read
  logic [31:0] macro [256];
  always @(posedge clk) begin
    if (!mem_cen) begin
      for (int i = 0; i < 4; i++)
        if (!mem_wen[i]) macro[mem_adr][8*i +: 8] <= mem_di[8*i +: 8];
      if (!mem_oen && (&mem_wen)) mem_dout <= macro[mem_adr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // transaction-level reference: memory contents as of each accept, response queue by due cycle
  typedef struct {
    int          due;
    bit          pb;
    logic [31:0] d;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] ref_mem [256];
  bit          have_exp = 1'b0;
  int          cyc = 0;
  int          clr_n = 0;
  bit          m_prio_b = 1'b0;
  logic        e_cen, e_oen, e_done, e_arv, e_brv;
  logic [3:0]  e_wen;
  logic [7:0]  e_adr;
  logic [31:0] e_di, e_ard, e_brd;
  logic        ea, eb, m_pb, m_we;
  logic [3:0]  m_be;
  logic [7:0]  m_ad;
  logic [31:0] m_wd;

  always @(negedge clk) begin
    ea = e_done & a_valid & (!b_valid | !m_prio_b);
    eb = e_done & b_valid & !ea;
    if (have_exp) begin
      chk("mem_cen", 32'(mem_cen), 32'(e_cen));
      chk("mem_wen", 32'(mem_wen), 32'(e_wen));
      chk("mem_oen", 32'(mem_oen), 32'(e_oen));
      chk("mem_adr", 32'(mem_adr), 32'(e_adr));
      chk("mem_di", mem_di, e_di);
      chk("init_done", 32'(init_done), 32'(e_done));
      chk("a_rvalid", 32'(a_rvalid), 32'(e_arv));
      chk("b_rvalid", 32'(b_rvalid), 32'(e_brv));
      chk("a_rdata", a_rdata, e_ard);
      chk("b_rdata", b_rdata, e_brd);
      chk("a_ready", 32'(a_ready), 32'(ea));
      chk("b_ready", 32'(b_ready), 32'(eb));
    end
    if (rst) begin
      e_cen = 1; e_wen = 4'hF; e_oen = 1; e_adr = 0; e_di = 0; e_done = 0;
      e_arv = 0; e_brv = 0; e_ard = 0; e_brd = 0;
      q.delete();
      m_prio_b = 0;
      clr_n = 0;
      have_exp = 1;
    end else if (have_exp) begin
      e_arv = 0; e_brv = 0;
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        if (q[0].pb) begin e_brv = 1; e_brd = q[0].d; end
        else begin e_arv = 1; e_ard = q[0].d; end
        void'(q.pop_front());
      end
      e_cen = 1; e_wen = 4'hF; e_oen = 1;
      if (clr_n < 256) begin
        e_cen = 0; e_wen = 0; e_adr = clr_n[7:0]; e_di = 0;
        ref_mem[clr_n] = 0;
        clr_n++;
        e_done = 0;
      end else begin
        if (ea | eb) begin
          m_pb = eb;
          m_we = eb ? b_we : a_we;
          m_be = eb ? b_be : a_be;
          m_ad = eb ? b_addr : a_addr;
          m_wd = eb ? b_wdata : a_wdata;
          m_prio_b = ea;
          if (m_we) begin
            if (m_be != 0) begin
              e_cen = 0; e_wen = ~m_be; e_adr = m_ad; e_di = m_wd;
              for (int i = 0; i < 4; i++)
                if (m_be[i]) ref_mem[m_ad][8*i +: 8] = m_wd[8*i +: 8];
            end
          end else begin
            e_cen = 0; e_oen = 0; e_adr = m_ad;
            q.push_back('{cyc + 3, m_pb, ref_mem[m_ad]});
          end
        end
        e_done = 1;
      end
    end
    cyc++;
  end

  task automatic req(input bit pb, input bit we, input logic [3:0] be, input logic [7:0] ad,
                     input logic [31:0] wd);
    bit ok = 0;
    if (pb) begin b_valid = 1; b_we = we; b_be = be; b_addr = ad; b_wdata = wd; end
    else begin a_valid = 1; a_we = we; a_be = be; a_addr = ad; a_wdata = wd; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = pb ? b_ready : a_ready;
    end
    chk("req_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
  endtask

  // edges: clock edges after the accept edge at which the response was registered
  task automatic rd(input bit pb, input logic [7:0] ad, output logic [31:0] d, output int edges);
    int lat = -1;
    req(pb, 0, 4'h0, ad, 32'h0);
    d = 'x;
    for (int i = 1; i <= 6 && lat < 0; i++) begin
      @(negedge clk);
      if (pb ? b_rvalid : a_rvalid) begin lat = i; d = pb ? b_rdata : a_rdata; end
    end
    edges = lat - 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_clear(input string nm);
    int done0 = 0, sweep = 0, bad = 0;
    for (int i = 0; i < 600 && !init_done; i++) begin
      @(negedge clk);
      if (!init_done) begin
        done0++;
        if (!mem_cen && mem_wen == 4'h0) begin
          if (mem_adr != sweep[7:0]) bad++;
          sweep++;
        end
      end
    end
    chk({nm, "_done_low_cycles"}, done0, 257);
    chk({nm, "_sweep_writes"}, sweep, 256);
    chk({nm, "_sweep_order_errs"}, bad, 0);
    @(posedge clk); #1;
  endtask

  logic [31:0] d;
  int          edges, n, found;
  logic [3:0]  g;
  int          idx [3];
  logic [31:0] vals [3];

  initial begin
    rst = 1;
    a_valid = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    wait_clear("clear0");

    a_valid = 1; a_we = 0; a_addr = 8'h7F;
    b_valid = 1; b_we = 0; b_addr = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g[i] = b_ready;
    end
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    chk("contention_grants", 32'(g), 32'b1010);
    repeat (4) @(posedge clk);
    #1;

    rd(0, 8'h7F, d, edges);
    chk("rd_7f_data", d, 32'h0);
    chk("rd_7f_latency", edges, 2);

    req(0, 1, 4'hF, 8'h10, 32'hDEADBEEF);
    req(0, 1, 4'h1, 8'h10, 32'h000000AA);
    @(negedge clk);
    chk("byte_wen", 32'(mem_wen), 32'b1110);
    @(posedge clk); #1;
    rd(0, 8'h10, d, edges);
    chk("rd_10_data", d, 32'hDEADBEAA);

    req(1, 1, 4'hF, 8'h20, 32'd1);
    req(1, 1, 4'hF, 8'h21, 32'd2);
    req(1, 1, 4'hF, 8'h22, 32'd3);
    b_valid = 1; b_we = 0;
    for (int i = 0; i < 3; i++) begin
      b_addr = 8'h20 + 8'(i);
      @(negedge clk);
      chk("b2b_ready", 32'(b_ready), 32'd1);
      @(posedge clk); #1;
    end
    b_valid = 0;
    n = 0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (b_rvalid) begin
        if (n < 3) begin idx[n] = j; vals[n] = b_rdata; end
        n++;
      end
    end
    @(posedge clk); #1;
    chk("b2b_count", n, 3);
    chk("b2b_consecutive", idx[2] - idx[0], 2);
    chk("b2b_data0", vals[0], 32'd1);
    chk("b2b_data1", vals[1], 32'd2);
    chk("b2b_data2", vals[2], 32'd3);

    req(1, 1, 4'hF, 8'h30, 32'h55);
    req(1, 1, 4'h0, 8'h30, 32'h99);
    @(negedge clk);
    chk("be0_no_cycle", 32'(mem_cen), 32'd1);
    @(posedge clk); #1;
    rd(1, 8'h30, d, edges);
    chk("rd_30_data", d, 32'h55);

    a_valid = 1; a_we = 0; a_addr = 8'h10;
    @(negedge clk);
    chk("pre_rst_accept", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    a_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (a_rvalid) n++;
    end
    chk("rst_drops_read", n, 0);
    found = 0;
    for (int j = 0; j < 300 && found == 0; j++) begin
      @(negedge clk);
      if (!mem_cen && mem_wen == 4'h0 && mem_adr == 8'd100 && !init_done) found = 1;
    end
    chk("reached_sweep_100", found, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    wait_clear("clear_restart");

    for (int i = 0; i < 3000; i++) begin
      a_valid = 1'($urandom); a_we = 1'($urandom); a_be = 4'($urandom);
      a_addr = 8'($urandom_range(0, 15)); a_wdata = $urandom;
      b_valid = 1'($urandom); b_we = 1'($urandom); b_be = 4'($urandom);
      b_addr = 8'($urandom_range(0, 15)); b_wdata = $urandom;
      @(posedge clk); #1;
    end
    a_valid = 0; b_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_bd_ram_ctrl.md
Name: eth_bd_ram_ctrl

Overview:
- Initiator-side controller for the 256x32 byte-write buffer-descriptor SRAM macro (active-low CEN/WEN[3:0]/OEN pin interface, one-cycle synchronous read).
- Arbitrates two requesters onto the single macro port: port A (host/register side) and port B (MAC TX/RX descriptor side).
- Sequences macro pin timing and returns read data to the correct requester.
- Optionally clears the whole array after reset.

Parameters:
AW, 8, address width; depth = 2**AW words
DW, 32, data width; byte lanes NB = DW/8
INIT_VAL, 0, word written to every location during the post-reset clear
CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = skip it

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
a_valid  input  1  port A request valid
a_ready  output  1  port A request accepted this cycle
a_we  input  1  1 = write, 0 = read
a_be  input  NB  active-high byte enables (writes only)
a_addr  input  AW  word address
a_wdata  input  DW  write data
a_rvalid  output  1  port A read data valid (single-cycle pulse)
a_rdata  output  DW  port A read data
b_valid, b_ready, b_we, b_be, b_addr, b_wdata, b_rvalid, b_rdata: identical to port A, for port B
init_done  output  1  clear sweep finished; requests may be accepted
mem_cen  output  1  macro chip enable, active low
mem_wen  output  NB  macro byte write enables, active low
mem_oen  output  1  macro output enable, active low
mem_adr  output  AW  macro address
mem_di  output  DW  macro write data
mem_dout  input  DW  macro read data

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - mem_cen=1, mem_wen=all 1s, mem_oen=1, mem_adr=0, mem_di=0.
  - a/b_rvalid=0, a/b_rdata=0, a/b_ready=0, init_done=0.
  - Arbiter pointer favours A.
- Pin registration: all mem_* outputs are registered.
- State machine, CLEAR:
  - Entered on reset release when CLEAR_ON_RESET=1.
  - Writes INIT_VAL to addresses 0..2**AW-1, one per cycle: mem_cen=0, mem_wen=0, mem_oen=1.
  - After the last address, go to RUN. init_done rises the cycle after the last write is driven.
  - Ready outputs are held 0 throughout.
- State machine, RUN:
  - Entered directly on reset release when CLEAR_ON_RESET=0; init_done=1 from the first cycle after reset.
- State machine, reset mid-operation:
  - rst during CLEAR restarts the sweep at address 0.
  - rst during RUN discards in-flight reads: no rvalid is produced for them.
- Arbitration (RUN only), round-robin:
  - Readies are combinational: x_ready = init_done & x_valid & grant_x.
  - Only one port is readied per cycle.
  - If only one port is valid, it is granted.
  - If both are valid, the port not granted last time wins. First contention after reset goes to A.
  - The pointer updates only on an accepted request.
- Command issue (accept edge E0), pins driven from E0:
  - Read: mem_cen=0, mem_wen=all 1s, mem_oen=0, mem_adr=addr.
  - Write with be!=0: mem_cen=0, mem_wen=~be, mem_oen=1, mem_adr=addr, mem_di=wdata.
  - Write with be==0: accepted, no macro cycle (mem_cen stays 1).
  - Idle cycle: mem_cen=1, mem_wen=all 1s, mem_oen=1. mem_adr and mem_di hold their last values.
- Read latency:
  - Macro samples at E1.
  - mem_dout is captured into x_rdata at E2.
  - x_rvalid is high for the cycle following E2: accept cycle + 2, one cycle only.
  - x_rdata holds its value until the next read response on that port.
- Responses have no backpressure. A 2-entry port-tag shift register routes each response.
- Throughput: one accepted command per cycle, reads and writes freely mixed.
- Ordering:
  - A read after a write to the same address, accepted on the following cycle, returns the new data. This follows from in-order macro access.
  - Within the written word, only the enabled bytes change.
- Address: no wrap logic is needed; an AW-bit address covers the array exactly.

Test Plan:
- Reset then clear: init_done=0 for 256 cycles with mem_adr 0..255 and mem_wen=0000; init_done=1 at cycle 257. A subsequent read of 0x7F returns 0x00000000 with a_rvalid at accept+2.
- Byte write: A writes 0xDEADBEEF to 0x10 with be=1111, then writes 0x000000AA with be=0001, then reads 0x10 -> a_rdata=0xDEADBEAA; mem_wen=1110 on the second write.
- Contention: a_valid and b_valid both held high, B doing reads of 0x01 -> grants alternate A,B,A,B starting with A. Each rvalid appears only on its own port, 2 cycles after its accept.
- Back-to-back: B reads 0x20, 0x21, 0x22 on consecutive cycles (preloaded 1,2,3) -> b_rvalid high for 3 consecutive cycles with b_rdata 1,2,3.
- be==0 write to 0x30 (preloaded 0x55) -> b_ready=1, mem_cen stays 1; a later read returns 0x55.
- rst asserted one cycle after a read is accepted -> no rvalid. rst asserted at sweep address 100 -> sweep restarts at 0 and init_done=1 only after a full 256-cycle sweep.
